// File: rtl/div64_seq_pkg.sv
// Shared definitions for the sequential 64-bit divider: operation encodings,
// widths, FSM state type and two's-complement helpers.
package div64_seq_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = 6;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    localparam logic [XLEN-1:0] DIV_MIN_SIGNED = 64'h8000_0000_0000_0000;
    localparam logic [XLEN-1:0] DIV_ALL_ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } div_state_e;

    function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] v);
        return ~v + 64'd1;
    endfunction

    // Magnitude of a signed operand; the most negative value maps to itself,
    // which is still the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? neg2c(v) : v;
    endfunction

endpackage

// File: rtl/div64_seq_step.sv
// One restoring-division iteration: shift {R,Q} left and conditionally subtract
// the divisor using a 65-bit difference whose top bit is the borrow.
module div_step
    import div64_seq_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] rem_sh_s;
    logic [XLEN:0] diff_s;

    // Shifted partial remainder can reach 2*divisor-1, hence the extra bit.
    always_comb begin
        rem_sh_s = {rem, quo[XLEN-1]};
        diff_s   = rem_sh_s - {1'b0, divisor};
        if (diff_s[XLEN] == 1'b0) begin
            rem_next = diff_s[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = rem_sh_s[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div64_seq.sv
// Iterative RV64 divider (DIV/DIVU/REM/REMU): one quotient bit per clock with
// a start/busy/done handshake, RISC-V special cases and synchronous flush.
module div64_seq
    import div64_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    div_state_e       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [1:0]       op_r, op_s;
    logic             neg_q_r, neg_q_s;
    logic             neg_rem_r, neg_rem_s;
    logic [XLEN-1:0]  rem_r, rem_s;
    logic [XLEN-1:0]  quo_r, quo_s;
    logic [XLEN-1:0]  div_r, div_s;
    logic [XLEN-1:0]  result_r, result_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;

    logic [XLEN-1:0]  step_rem_s;
    logic [XLEN-1:0]  step_quo_s;
    logic             is_signed_s;

    div_step u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (div_r),
        .rem_next (step_rem_s),
        .quo_next (step_quo_s)
    );

    // Next-state and datapath update for the IDLE/RUN/FIX sequence.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        op_s        = op_r;
        neg_q_s     = neg_q_r;
        neg_rem_s   = neg_rem_r;
        rem_s       = rem_r;
        quo_s       = quo_r;
        div_s       = div_r;
        result_s    = result_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        is_signed_s = ~op[0];

        case (state_r)
            ST_IDLE: begin
                if (flush) begin
                    state_s = ST_IDLE;
                end else if (start) begin
                    op_s   = op;
                    busy_s = 1'b1;
                    div_s  = mag(b, is_signed_s);
                    if (b == {XLEN{1'b0}}) begin
                        // Special results are preloaded so FIX passes them through unsigned.
                        quo_s     = DIV_ALL_ONES;
                        rem_s     = a;
                        neg_q_s   = 1'b0;
                        neg_rem_s = 1'b0;
                        state_s   = ST_FIX;
                    end else if (is_signed_s && (a == DIV_MIN_SIGNED) && (b == DIV_ALL_ONES)) begin
                        quo_s     = a;
                        rem_s     = {XLEN{1'b0}};
                        neg_q_s   = 1'b0;
                        neg_rem_s = 1'b0;
                        state_s   = ST_FIX;
                    end else begin
                        quo_s     = mag(a, is_signed_s);
                        rem_s     = {XLEN{1'b0}};
                        cnt_s     = {CNT_W{1'b0}};
                        neg_q_s   = is_signed_s & (a[XLEN-1] ^ b[XLEN-1]);
                        neg_rem_s = is_signed_s & a[XLEN-1];
                        state_s   = ST_RUN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end else begin
                    rem_s = step_rem_s;
                    quo_s = step_quo_s;
                    cnt_s = cnt_r + 6'd1;
                    if (cnt_r == {CNT_W{1'b1}}) begin
                        state_s = ST_FIX;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end else begin
                    if (op_r[1]) begin
                        result_s = neg_rem_r ? neg2c(rem_r) : rem_r;
                    end else begin
                        result_s = neg_q_r ? neg2c(quo_r) : quo_r;
                    end
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            op_r      <= 2'b00;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            rem_r     <= {XLEN{1'b0}};
            quo_r     <= {XLEN{1'b0}};
            div_r     <= {XLEN{1'b0}};
            result_r  <= {XLEN{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            op_r      <= op_s;
            neg_q_r   <= neg_q_s;
            neg_rem_r <= neg_rem_s;
            rem_r     <= rem_s;
            quo_r     <= quo_s;
            div_r     <= div_s;
            result_r  <= result_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_div64_seq.sv
// Directed bench for div64_seq: expected results come from a behavioural
// model pushed to a queue at issue and popped when done is seen.
module tb_div64_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int e0_cyc      = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_exp;

    localparam logic [63:0] MIN64  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    div64_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    function automatic logic [63:0] model(input logic [1:0] mop, input logic [63:0] ma, input logic [63:0] mb);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0] r;
        sa = ma;
        sb = mb;
        if (mb == 64'd0) begin
            r = mop[1] ? ma : ONES64;
        end else if (!mop[0] && ma == MIN64 && mb == ONES64) begin
            r = mop[1] ? 64'd0 : ma;
        end else begin
            case (mop)
                2'b00:   r = sa / sb;
                2'b01:   r = ma / mb;
                2'b10:   r = sa % sb;
                default: r = ma % mb;
            endcase
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called #1 after an edge: drives one start pulse and records E0.
    task automatic issue(input string tag, input logic [1:0] iop, input logic [63:0] ia,
                         input logic [63:0] ib, input bit keep);
        start = 1'b1;
        op    = iop;
        a     = ia;
        b     = ib;
        @(posedge clk);
        #1;
        start  = 1'b0;
        e0_cyc = cyc;
        if (keep) begin
            last_exp = model(iop, ia, ib);
            exp_q.push_back(last_exp);
        end
        check({tag, "_busy_on"}, {63'd0, busy}, 64'd1);
        check({tag, "_done_low"}, {63'd0, done}, 64'd0);
    endtask

    task automatic wait_result(input string tag, input int lat);
        int n;
        bit seen;
        logic [63:0] expv;
        n    = 0;
        seen = 1'b0;
        while (n < 80 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
        end
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'd0;
        if (!seen) begin
            check({tag, "_timeout"}, {63'd0, done}, 64'd1);
        end else begin
            check({tag, "_latency"}, 64'(cyc - e0_cyc), 64'(lat));
            check({tag, "_busy_off"}, {63'd0, busy}, 64'd0);
            check({tag, "_result"}, result, expv);
        end
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        bit saw;
        saw = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) saw = 1'b1;
        end
        check(tag, {63'd0, saw}, 64'd0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [63:0] ra;
        logic [63:0] rb;

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        a     = 64'd0;
        b     = 64'd0;
        #12;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_result", result, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue("divu", 2'b01, 64'd100, 64'd7, 1'b1);
        wait_result("divu", 65);
        issue("remu", 2'b11, 64'd100, 64'd7, 1'b1);
        wait_result("remu", 65);
        issue("div_neg", 2'b00, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1);
        wait_result("div_neg", 65);
        issue("rem_neg", 2'b10, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1);
        wait_result("rem_neg", 65);

        issue("divu_by0", 2'b01, 64'd5, 64'd0, 1'b1);
        wait_result("divu_by0", 1);
        issue("rem_by0", 2'b10, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1);
        wait_result("rem_by0", 1);
        issue("div_ovf", 2'b00, MIN64, ONES64, 1'b1);
        wait_result("div_ovf", 1);
        issue("rem_ovf", 2'b10, MIN64, ONES64, 1'b1);
        wait_result("rem_ovf", 1);

        issue("divu_bigdiv", 2'b01, ONES64, 64'h8000_0000_0000_0001, 1'b1);
        wait_result("divu_bigdiv", 65);
        issue("remu_bigdiv", 2'b11, ONES64, 64'h8000_0000_0000_0001, 1'b1);
        wait_result("remu_bigdiv", 65);
        issue("rem_negdiv", 2'b10, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1);
        wait_result("rem_negdiv", 65);
        issue("div_min3", 2'b00, MIN64, 64'd3, 1'b1);
        wait_result("div_min3", 65);

        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom} >> $urandom_range(0, 60);
            if (rb == 64'd0) rb = 64'd3;
            issue("rand", rop, ra, rb, 1'b1);
            wait_result("rand", 65);
        end

        // Start while busy must be ignored.
        @(posedge clk);
        #1;
        issue("ign", 2'b01, 64'd1000, 64'd3, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b11;
        a     = 64'd55;
        b     = 64'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign_busy", {63'd0, busy}, 64'd1);
        wait_result("ign", 65);

        // Flush mid-RUN: no done, result keeps the previous value.
        @(posedge clk);
        #1;
        issue("flush_run", 2'b01, 64'd12345, 64'd6, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_done", {63'd0, done}, 64'd0);
        check("flush_result", result, last_exp);
        watch_no_done("flush_no_done", 70);

        // Flush in IDLE drops a simultaneous start.
        start = 1'b1;
        flush = 1'b1;
        op    = 2'b01;
        a     = 64'd9;
        b     = 64'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("idle_flush_busy", {63'd0, busy}, 64'd0);
        watch_no_done("idle_flush_no_done", 70);
        check("idle_flush_result", result, last_exp);

        // Back-to-back: second start in the done cycle.
        issue("b2b_first", 2'b01, 64'd81, 64'd9, 1'b1);
        wait_result("b2b_first", 65);
        issue("b2b_second", 2'b11, 64'd81, 64'd10, 1'b1);
        wait_result("b2b_second", 65);

        // Asynchronous reset between edges mid-RUN.
        @(posedge clk);
        #1;
        issue("rst_run", 2'b01, 64'd777, 64'd5, 1'b0);
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_result", result, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_idle_busy", {63'd0, busy}, 64'd0);
        issue("post_rst", 2'b01, ONES64, 64'd1, 1'b1);
        wait_result("post_rst", 65);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
